slot_fifo_arbiter: RTL and testbench

//  Shares one byte-wide FIFO read port between NUM_SLOTS slot modules (DAC-style sample consumers).

---
 rtl/slot_fifo_arbiter_pkg.sv | 14 +
 rtl/slot_fifo_arbiter_rr_pick.sv | 34 +++
 rtl/slot_fifo_arbiter.sv | 110 +++++++++++
 tb/tb_slot_fifo_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_fifo_arbiter_pkg.sv
// slot_fifo_arbiter_pkg: shared defaults, FSM encoding and counter helper
// for the slot FIFO read-port arbiter.
package slot_fifo_arbiter_pkg;
    localparam int BURST_BYTES_DEF = 4;
    localparam int ADDR_WIDTH_DEF  = 11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/slot_fifo_arbiter_rr_pick.sv
// slot_fifo_arbiter_rr_pick: round-robin winner select; the pointer remembers
// the last winner so the search starts one slot past it.
module slot_fifo_arbiter_rr_pick
    import slot_fifo_arbiter_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SLOTS-1:0] req,
    input  logic                 take,
    output logic [NUM_SLOTS-1:0] winner
);
    logic [2:0] ptr_q, ptr_d, win_idx;
    int idx;
    always_comb begin
        winner  = '0;
        win_idx = ptr_q;
        idx     = 0;
        // Scan farthest-first so the nearest requester after the pointer wins.
        for (int i = NUM_SLOTS; i >= 1; i--) begin
            idx = (int'(ptr_q) + i) % NUM_SLOTS;
            if (|((req >> idx) & NUM_SLOTS'(1))) begin
                winner  = NUM_SLOTS'(1) << idx;
                win_idx = 3'(idx);
            end
        end
        ptr_d = take ? win_idx : ptr_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= 3'(NUM_SLOTS - 1);
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/slot_fifo_arbiter.sv
// slot_fifo_arbiter: shares one byte-wide FIFO read port between NUM_SLOTS
// consumers, reading one BURST_BYTES frame per round-robin grant.
module slot_fifo_arbiter
    import slot_fifo_arbiter_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int BURST_BYTES  = BURST_BYTES_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fifo_clk,
    input  logic [ADDR_WIDTH-1:0] fifo_addr_in,
    input  logic [ADDR_WIDTH-1:0] fifo_addr_out,
    output logic                  fifo_read,
    input  logic [7:0]            fifo_data,
    input  logic [NUM_SLOTS-1:0]  req,
    output logic [NUM_SLOTS-1:0]  grant,
    output logic [7:0]            slot_byte,
    output logic                  slot_byte_valid,
    output logic [2:0]            slot_byte_index,
    output logic                  burst_done,
    output logic                  busy,
    output logic [15:0]           starve_count
);
    state_e                        state_q, state_d;
    logic [NUM_SLOTS-1:0]          grant_q, grant_d, winner;
    logic [2:0]                    cnt_q, cnt_d;
    logic                          read_q, read_d, take;
    logic [15:0]                   starve_q, starve_d;
    logic [7:0]                    slot_byte_q, slot_byte_d;
    logic [READ_LATENCY:0][3:0]    pipe_q, pipe_d;
    logic [ADDR_WIDTH-1:0]         level;

    assign fifo_clk        = clk;
    assign level           = fifo_addr_in - fifo_addr_out;
    assign grant           = grant_q;
    assign fifo_read       = read_q;
    assign slot_byte       = slot_byte_q;
    assign starve_count    = starve_q;
    assign busy            = state_q != ST_IDLE;
    assign slot_byte_valid = pipe_q[READ_LATENCY][3];
    assign slot_byte_index = pipe_q[READ_LATENCY][2:0];
    assign burst_done      = slot_byte_valid && slot_byte_index == 3'(BURST_BYTES - 1);

    slot_fifo_arbiter_rr_pick #(.NUM_SLOTS(NUM_SLOTS)) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .take   (take),
        .winner (winner)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        read_d   = read_q;
        starve_d = starve_q;
        take     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req && level >= ADDR_WIDTH'(BURST_BYTES)) begin
                    take    = 1'b1;
                    grant_d = winner;
                    read_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end else if (|req) begin
                    starve_d = sat_inc16(starve_q);
                end
            end
            ST_BURST: begin
                read_d  = cnt_q != 3'(BURST_BYTES - 1);
                cnt_d   = read_d ? cnt_q + 3'd1 : cnt_q;
                state_d = read_d ? ST_BURST : ST_DRAIN;
            end
            ST_DRAIN: begin
                // Grant is held until the last byte has reached the slot.
                state_d = burst_done ? ST_IDLE : ST_DRAIN;
                grant_d = burst_done ? '0 : grant_q;
            end
            default: state_d = ST_IDLE;
        endcase
        // Strobe and byte counter travel together so index lines up with returned data.
        pipe_d      = {pipe_q[READ_LATENCY-1:0], read_q, cnt_q};
        slot_byte_d = pipe_q[READ_LATENCY-1][3] ? fifo_data : slot_byte_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            read_q      <= 1'b0;
            starve_q    <= '0;
            slot_byte_q <= '0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            read_q      <= read_d;
            starve_q    <= starve_d;
            slot_byte_q <= slot_byte_d;
            pipe_q      <= pipe_d;
        end
    end
endmodule

// File: tb/tb_slot_fifo_arbiter.sv
// tb_slot_fifo_arbiter: drives request/level scenarios into slot_fifo_arbiter,
// feeds bytes through a latency-1 FIFO model and checks each returned byte.
module tb_slot_fifo_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_clk, fifo_read, slot_byte_valid, burst_done, busy;
    logic [10:0] ain = 11'd0, aout = 11'd0;
    logic [7:0]  fifo_data = 8'h00, slot_byte;
    logic [3:0]  req = 4'b0000, grant;
    logic [2:0]  slot_byte_index;
    logic [15:0] starve_count;

    typedef struct {
        logic [3:0] g;
        logic [7:0] b;
        logic [2:0] idx;
    } exp_t;
    typedef struct {
        logic [3:0]  req;
        logic [10:0] ain;
        logic [10:0] aout;
        logic [3:0]  exp_g;
        logic [7:0]  base;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    exp_t       mon_e;
    int         n_cmp = 0, n_err = 0, reads = 0, dones = 0, cyc = 0, last_done = -1;
    bit         mon_en = 1'b1, rr_phase = 1'b0;
    logic       rd_neg = 1'b0;

    slot_fifo_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_clk        (fifo_clk),
        .fifo_addr_in    (ain),
        .fifo_addr_out   (aout),
        .fifo_read       (fifo_read),
        .fifo_data       (fifo_data),
        .req             (req),
        .grant           (grant),
        .slot_byte       (slot_byte),
        .slot_byte_valid (slot_byte_valid),
        .slot_byte_index (slot_byte_index),
        .burst_done      (burst_done),
        .busy            (busy),
        .starve_count    (starve_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [3:0] g, input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(base + 8'(i));
            exp_q.push_back('{g, base + 8'(i), 3'(i)});
        end
    endtask

    task automatic wait_grant();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = grant != 4'b0000;
        end
        chk("grant_seen", 32'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        chk("idle_seen", 32'(ok), 1);
    endtask

    task automatic wait_reads(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = reads >= target;
        end
        chk("reads_seen", 32'(ok), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rd_neg) begin
            if (src_q.size() > 0) fifo_data = src_q.pop_front();
            else                  fifo_data = 8'h00;
        end
    end

    initial forever begin
        @(negedge clk);
        rd_neg = fifo_read;
        if (fifo_read) reads++;
        if (mon_en && slot_byte_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(slot_byte_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("byte", 32'(slot_byte), 32'(mon_e.b));
                chk("index", 32'(slot_byte_index), 32'(mon_e.idx));
                chk("byte_grant", 32'(grant), 32'(mon_e.g));
                chk("done_flag", 32'(burst_done), 32'(mon_e.idx == 3'd3));
            end
        end
        if (mon_en && burst_done) begin
            dones++;
            if (rr_phase && last_done >= 0) chk("rr_period", 32'(cyc - last_done), 7);
            last_done = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   order[8];
        int   r0, d0;
        tbl[0] = '{4'b0100, 11'd8,    11'd0,    4'b0100, 8'hA0};
        tbl[1] = '{4'b0011, 11'd16,   11'd0,    4'b0001, 8'h20};
        tbl[2] = '{4'b0011, 11'd16,   11'd0,    4'b0010, 8'h30};
        tbl[3] = '{4'b1000, 11'd2,    11'd2046, 4'b1000, 8'h40};
        tbl[4] = '{4'b1001, 11'd5,    11'd0,    4'b0001, 8'h50};
        tbl[5] = '{4'b0110, 11'd1027, 11'd1023, 4'b0010, 8'h60};
        order  = '{2, 3, 0, 1, 2, 3, 0, 1};

        ain = 11'd100;
        repeat (3) @(negedge clk);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_read", 32'(fifo_read), 0);
        chk("rst_starve", 32'(starve_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(slot_byte_valid), 0);
        push_frame(4'b0001, 8'h10);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_grant", 32'(grant), 32'h1);
        chk("rel_read", 32'(fifo_read), 1);
        req = 4'b0000;
        wait_idle();
        chk("rel_sb_empty", 32'(exp_q.size()), 0);

        for (int i = 0; i < 6; i++) begin
            r0   = reads;
            ain  = tbl[i].ain;
            aout = tbl[i].aout;
            push_frame(tbl[i].exp_g, tbl[i].base);
            req = tbl[i].req;
            wait_grant();
            chk("tbl_grant", 32'(grant), 32'(tbl[i].exp_g));
            chk("tbl_busy", 32'(busy), 1);
            req = 4'b0000;
            wait_idle();
            chk("tbl_reads", 32'(reads - r0), 4);
            chk("tbl_sb_empty", 32'(exp_q.size()), 0);
        end

        ain = 11'd64; aout = 11'd0;
        for (int k = 0; k < 8; k++) push_frame(4'(1 << order[k]), 8'h80 + 8'(k * 8));
        d0 = dones; rr_phase = 1'b1; last_done = -1;
        req = 4'b1111;
        for (int i = 0; i < 100 && (dones - d0) < 8; i++) @(negedge clk);
        req = 4'b0000;
        rr_phase = 1'b0;
        chk("rr_bursts", 32'(dones - d0), 8);
        wait_idle();
        chk("rr_sb_empty", 32'(exp_q.size()), 0);

        ain = 11'd3; aout = 11'd0;
        push_frame(4'b0010, 8'hC0);
        req = 4'b0010;
        repeat (10) @(negedge clk);
        chk("starve_cnt", 32'(starve_count), 10);
        chk("starve_grant", 32'(grant), 0);
        ain = 11'd4;
        @(negedge clk);
        chk("starve_release", 32'(grant), 32'b0010);
        req = 4'b0000;
        wait_idle();
        chk("starve_hold", 32'(starve_count), 10);
        chk("starve_sb_empty", 32'(exp_q.size()), 0);

        ain = 11'd64; r0 = reads;
        push_frame(4'b0001, 8'hD0);
        req = 4'b0001;
        wait_grant();
        wait_reads(r0 + 2);
        req = 4'b0000;
        wait_idle();
        chk("drop_reads", 32'(reads - r0), 4);
        chk("drop_sb_empty", 32'(exp_q.size()), 0);

        mon_en = 1'b0; r0 = reads;
        req = 4'b0010;
        wait_grant();
        chk("abort_grant", 32'(grant), 32'b0010);
        wait_reads(r0 + 2);
        #1 reset = 1'b0;
        #1;
        chk("abort_grant_clr", 32'(grant), 0);
        chk("abort_read_clr", 32'(fifo_read), 0);
        chk("abort_busy_clr", 32'(busy), 0);
        chk("abort_valid_clr", 32'(slot_byte_valid), 0);
        chk("abort_byte_clr", 32'(slot_byte), 0);
        chk("abort_starve_clr", 32'(starve_count), 0);
        r0 = reads;
        repeat (3) @(negedge clk);
        chk("abort_no_reads", 32'(reads - r0), 0);
        req = 4'b0000;
        reset = 1'b1;
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;

        push_frame(4'b0001, 8'hE0);
        req = 4'b1111;
        wait_grant();
        chk("post_rst_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        wait_idle();
        chk("post_rst_sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
